fetch_redirect_ctrl: RTL and testbench

//   Sequences the fetch PC around the frontend branch predictor.
//   - Each fetched instruction's predicted next PC is recorded in an in-order queue.
//   - When EX resolves the real next PC, it is compared with the oldest prediction.
//   - On mismatch: redirect fetch, flush in-flight predictions, and drive the

---
 rtl/bpb_pkg.sv | 18 +
 rtl/pred_queue.sv | 68 ++++++
 rtl/fetch_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpb_pkg.sv
// Shared types and defaults for the fetch redirect controller.
package bpb_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;

    // One in-flight prediction: where it was fetched, what it was, where we guessed it goes.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pred;
    } pred_entry_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of outstanding predictions; clear wins over push/pop.
module pred_queue
    import bpb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t wdata,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_d;
    pred_entry_t   r_mem [DEPTH];

    logic w_pop;
    logic w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (AW + 1)'(DEPTH));
    assign head   = r_mem[r_rd_ptr];
    assign w_pop  = pop & ~empty;
    // At full a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
    assign w_push = push & (~full | w_pop);

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_push && !clear) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: checks resolved next-PCs against queued predictions and redirects on miss.
module fetch_redirect_ctrl
    import bpb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] pred_pc,
    input  logic        stall,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    output logic [31:0] pc,
    output logic        miss,
    output logic [31:0] prev_pc,
    output logic [31:0] prev_instr,
    output logic        flush,
    output logic        full,
    output logic        err,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_d;
    logic [31:0] r_pc;
    logic        r_miss;
    logic [31:0] r_prev_pc;
    logic [31:0] r_prev_instr;
    logic        r_err;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    pred_entry_t w_head;
    pred_entry_t w_wdata;
    logic        w_full;
    logic        w_empty;
    logic        w_hit;
    logic        w_mismatch;
    logic        w_push;

    assign w_hit      = resolve_valid & ~w_empty & (w_head.pred == resolve_pc);
    assign w_mismatch = resolve_valid & ~w_empty & ~w_hit;
    // The queue is always empty in RECOVER, so only push needs the state gate.
    assign w_push     = (r_state == RUN) & ~w_mismatch & fetch_valid & ~stall & (~w_full | w_hit);
    assign w_wdata    = '{pc: r_pc, instr: fetch_instr, pred: pred_pc};

    pred_queue #(
        .DEPTH (DEPTH)
    ) u_pred_queue (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_hit),
        .clear (w_mismatch),
        .wdata (w_wdata),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Next-state: one recovery cycle after every mispredict.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            RUN:     if (w_mismatch) w_state_d = RECOVER;
            RECOVER: w_state_d = RUN;
            default: w_state_d = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_d;
    end

    // Fetch PC: redirect beats prediction, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_pc <= RESET_PC;
        else if (w_mismatch) r_pc <= resolve_pc;
        else if (w_push)     r_pc <= pred_pc;
    end

    // Mispredict feedback to the predictor; prev_* keep the last miss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_miss       <= 1'b0;
            r_prev_pc    <= '0;
            r_prev_instr <= '0;
        end else begin
            r_miss <= w_mismatch;
            if (w_mismatch) begin
                r_prev_pc    <= w_head.pc;
                r_prev_instr <= w_head.instr;
            end
        end
    end

    // Sticky error for a resolve with nothing outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          r_err <= 1'b0;
        else if (resolve_valid && w_empty)  r_err <= 1'b1;
    end

    // Saturating hit/miss statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != '1))       r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_mismatch && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign pc         = r_pc;
    assign miss       = r_miss;
    assign prev_pc    = r_prev_pc;
    assign prev_instr = r_prev_instr;
    assign flush      = (r_state == RECOVER);
    assign full       = w_full;
    assign err        = r_err;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed stimulus queues expectations, a monitor checks.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RPC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic [31:0] pred_pc = '0;
    logic        stall = 1'b0;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = '0;
    logic [31:0] pc;
    logic        miss;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        flush;
    logic        full;
    logic        err;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    fetch_redirect_ctrl #(
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .pred_pc       (pred_pc),
        .stall         (stall),
        .resolve_valid (resolve_valid),
        .resolve_pc    (resolve_pc),
        .pc            (pc),
        .miss          (miss),
        .prev_pc       (prev_pc),
        .prev_instr    (prev_instr),
        .flush         (flush),
        .full          (full),
        .err           (err),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          tag;
        bit          phase;
        bit          kind;   // 0: main outputs, 1: prev_pc/prev_instr
        logic [31:0] pc;
        logic        miss;
        logic        flush;
        logic        full;
        logic        err;
        logic [31:0] hc;
        logic [31:0] mc;
        logic [31:0] ppc;
        logic [31:0] pinstr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    task automatic expect_out(input string name, input logic [31:0] e_pc, input logic e_miss,
                              input logic e_flush, input logic e_full, input logic e_err,
                              input logic [31:0] e_hc, input logic [31:0] e_mc,
                              input bit ph = 1'b0);
        exp_t e;
        e.name = name; e.tag = ph ? cyc : cyc + 1; e.phase = ph; e.kind = 1'b0;
        e.pc = e_pc; e.miss = e_miss; e.flush = e_flush; e.full = e_full; e.err = e_err;
        e.hc = e_hc; e.mc = e_mc; e.ppc = '0; e.pinstr = '0;
        exp_q.push_back(e);
    endtask

    task automatic expect_prev(input string name, input logic [31:0] e_ppc,
                               input logic [31:0] e_pinstr);
        exp_t e;
        e.name = name; e.tag = cyc + 1; e.phase = 1'b0; e.kind = 1'b1;
        e.pc = '0; e.miss = 1'b0; e.flush = 1'b0; e.full = 1'b0; e.err = 1'b0;
        e.hc = '0; e.mc = '0; e.ppc = e_ppc; e.pinstr = e_pinstr;
        exp_q.push_back(e);
    endtask

    task automatic check_phase(input bit ph);
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].tag == cyc && exp_q[0].phase == ph) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.kind) begin
                if (prev_pc !== e.ppc || prev_instr !== e.pinstr) begin
                    n_fail++;
                    $display("FAIL %s: prev_pc=%h prev_instr=%h, required prev_pc=%h prev_instr=%h",
                             e.name, prev_pc, prev_instr, e.ppc, e.pinstr);
                end
            end else if (pc !== e.pc || miss !== e.miss || flush !== e.flush || full !== e.full ||
                         err !== e.err || hit_cnt !== e.hc || miss_cnt !== e.mc) begin
                n_fail++;
                $display("FAIL %s: got pc=%h miss=%b flush=%b full=%b err=%b hit=%0d miss_cnt=%0d, required pc=%h miss=%b flush=%b full=%b err=%b hit=%0d miss_cnt=%0d",
                         e.name, pc, miss, flush, full, err, hit_cnt, miss_cnt,
                         e.pc, e.miss, e.flush, e.full, e.err, e.hc, e.mc);
            end
        end
    endtask

    // Monitor: regular checks at the falling edge, reset-between-edges checks 3 units later.
    initial begin
        forever begin
            @(negedge clk);
            check_phase(1'b0);
            #3;
            check_phase(1'b1);
        end
    end

    task automatic step(input logic fv, input logic [31:0] instr, input logic [31:0] pred,
                        input logic st, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        #1;
        fetch_valid = fv; fetch_instr = instr; pred_pc = pred;
        stall = st; resolve_valid = rv; resolve_pc = rpc;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input string name);
        idle();
        reset = 1'b1;
        expect_out({name, "_held"}, RPC, 0, 0, 0, 0, 0, 0);
        idle();
        reset = 1'b0;
        expect_out({name, "_released"}, RPC, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset("reset");

        // Streaming hits, resolves trailing fetches by one cycle.
        step(1, 32'h11111111, RPC + 32'h4, 0, 0, '0);
        expect_out("hit_f0", RPC + 32'h4, 0, 0, 0, 0, 0, 0);
        step(1, 32'h22222222, RPC + 32'h8, 0, 1, RPC + 32'h4);
        expect_out("hit_r0", RPC + 32'h8, 0, 0, 0, 0, 1, 0);
        step(1, 32'h33333333, RPC + 32'hc, 0, 1, RPC + 32'h8);
        expect_out("hit_r1", RPC + 32'hc, 0, 0, 0, 0, 2, 0);
        step(1, 32'h44444444, RPC + 32'h10, 0, 1, RPC + 32'hc);
        expect_out("hit_r2", RPC + 32'h10, 0, 0, 0, 0, 3, 0);
        step(0, '0, '0, 0, 1, RPC + 32'h10);
        expect_out("hit_r3", RPC + 32'h10, 0, 0, 0, 0, 4, 0);
        idle();
        expect_out("hit_drained", RPC + 32'h10, 0, 0, 0, 0, 4, 0);

        // Mispredict then resolve against the flushed (empty) queue.
        do_reset("reset2");
        step(1, 32'haaaa0001, RPC + 32'h4, 0, 0, '0);
        expect_out("mp_fetch", RPC + 32'h4, 0, 0, 0, 0, 0, 0);
        step(1, 32'haaaa0002, RPC + 32'h8, 0, 1, 32'hbfc00100);
        expect_out("mp_redirect", 32'hbfc00100, 1, 1, 0, 0, 0, 1);
        expect_prev("mp_prev", RPC, 32'haaaa0001);
        step(1, 32'haaaa0003, 32'h12345678, 0, 0, '0);
        expect_out("mp_recover_done", 32'hbfc00100, 0, 0, 0, 0, 0, 1);
        step(0, '0, '0, 0, 1, 32'hbfc00104);
        expect_out("mp_empty_err", 32'hbfc00100, 0, 0, 0, 1, 0, 1);
        idle();
        expect_out("err_sticky", 32'hbfc00100, 0, 0, 0, 1, 0, 1);

        // Full queue, hit+push at full, stalled hit.
        do_reset("reset3");
        step(1, 32'h0, RPC + 32'h4, 0, 0, '0);
        expect_out("fill0", RPC + 32'h4, 0, 0, 0, 0, 0, 0);
        step(1, 32'h1, RPC + 32'h8, 0, 0, '0);
        expect_out("fill1", RPC + 32'h8, 0, 0, 0, 0, 0, 0);
        step(1, 32'h2, RPC + 32'hc, 0, 0, '0);
        expect_out("fill2", RPC + 32'hc, 0, 0, 0, 0, 0, 0);
        step(1, 32'h3, RPC + 32'h10, 0, 0, '0);
        expect_out("fill3_full", RPC + 32'h10, 0, 0, 1, 0, 0, 0);
        step(1, 32'h4, RPC + 32'h14, 0, 0, '0);
        expect_out("full_pc_held", RPC + 32'h10, 0, 0, 1, 0, 0, 0);
        step(1, 32'h4, RPC + 32'h14, 0, 1, RPC + 32'h4);
        expect_out("full_hit_push", RPC + 32'h14, 0, 0, 1, 0, 1, 0);
        step(1, 32'h5, RPC + 32'h18, 1, 1, RPC + 32'h8);
        expect_out("stall_hit", RPC + 32'h14, 0, 0, 0, 0, 2, 0);
        step(0, '0, '0, 0, 1, RPC + 32'hc);
        expect_out("drain2", RPC + 32'h14, 0, 0, 0, 0, 3, 0);
        step(0, '0, '0, 0, 1, RPC + 32'h10);
        expect_out("drain3", RPC + 32'h14, 0, 0, 0, 0, 4, 0);
        step(0, '0, '0, 0, 1, RPC + 32'h14);
        expect_out("drain_pushed_at_full", RPC + 32'h14, 0, 0, 0, 0, 5, 0);
        step(0, '0, '0, 0, 1, RPC + 32'h18);
        expect_out("empty_err", RPC + 32'h14, 0, 0, 0, 1, 5, 0);

        // Async reset while in RECOVER.
        step(1, 32'hbeef0000, RPC + 32'h18, 0, 0, '0);
        expect_out("ar_fetch", RPC + 32'h18, 0, 0, 0, 1, 5, 0);
        step(0, '0, '0, 0, 1, 32'hbfc00200);
        expect_out("ar_redirect", 32'hbfc00200, 1, 1, 0, 1, 5, 1);
        expect_prev("ar_prev", RPC + 32'h14, 32'hbeef0000);
        idle();
        #1;
        reset = 1'b1;
        expect_out("ar_immediate", RPC, 0, 0, 0, 0, 0, 0, 1'b1);
        idle();
        reset = 1'b0;
        expect_out("ar_released", RPC, 0, 0, 0, 0, 0, 0);
        stim_done = 1'b1;
    end

    // Bounded drain of the scoreboard, then summary.
    initial begin
        wait (stim_done);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #4;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, required tag %0d got cycle %0d", e.name, e.tag, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
